// File: rtl/multi_cycle_adder_if.sv
// Handshake and data bundle for multi_cycle_adder.
// Carries the request side (Start_In, operands, carry/borrow-in, Sub_In) and the
// result side (Sum_Out, Carry_Out, Overflow_Out, Busy_Out, Done_Out); clock/reset stay outside.
interface multi_cycle_adder_if #(
    parameter int WIDTH = 8
);
    logic             Start_In;
    logic [WIDTH-1:0] Data_A_In;
    logic [WIDTH-1:0] Data_B_In;
    logic             Carry_In;
    logic             Sub_In;
    logic [WIDTH-1:0] Sum_Out;
    logic             Carry_Out;
    logic             Overflow_Out;
    logic             Busy_Out;
    logic             Done_Out;

    // Requester side: drives the operation, observes results.
    modport master (
        output Start_In, Data_A_In, Data_B_In, Carry_In, Sub_In,
        input  Sum_Out, Carry_Out, Overflow_Out, Busy_Out, Done_Out
    );

    // Adder side.
    modport slave (
        input  Start_In, Data_A_In, Data_B_In, Carry_In, Sub_In,
        output Sum_Out, Carry_Out, Overflow_Out, Busy_Out, Done_Out
    );
endinterface

// File: rtl/multi_cycle_adder.sv
// Multi-cycle adder/subtractor: adds WIDTH-bit operands DIGIT_WIDTH bits per clock
// through a ripple of full-adder slices with a registered inter-digit carry.
// Ports: Clock, Reset (sync, active-high), bus (slave modport: start/operands in,
// sum/carry/overflow/busy/done out). Latency N+1 cycles, N = WIDTH/DIGIT_WIDTH;
// Start_In is only taken in IDLE or DONE, ignored while an operation is in flight.
module multi_cycle_adder #(
    parameter int WIDTH       = 8,
    parameter int DIGIT_WIDTH = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    multi_cycle_adder_if.slave bus
);

    localparam int N     = WIDTH / DIGIT_WIDTH;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    generate
        if (WIDTH < 2 || DIGIT_WIDTH < 1 || (WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_param
            $error("multi_cycle_adder: WIDTH must be >= 2 and a multiple of DIGIT_WIDTH >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand / progress registers
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             msb_cin_q, msb_cin_d;
    logic             msb_cout_q, msb_cout_d;

    // Published outputs
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Digit slice datapath
    logic [DIGIT_WIDTH-1:0] a_dig;
    logic [DIGIT_WIDTH-1:0] b_dig;
    logic [DIGIT_WIDTH-1:0] s_dig;
    logic [DIGIT_WIDTH:0]   c_chain;
    logic                   start_acc;

    // Both IDLE and DONE accept a new request; ADD ignores Start_In.
    always_comb begin
        start_acc = bus.Start_In && (state_q != ADD);
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.Start_In) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                if (cnt_q == LAST_DIGIT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = bus.Start_In ? ADD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Busy/Done are registered decodes of the state, so they trail the state by
    // one cycle; results are copied from the shadow while the FSM sits in DONE
    // and so become visible together with Done_Out.
    always_comb begin
        busy_d = (state_q == ADD);
        done_d = (state_q == DONE);
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (state_q == DONE) begin
            sum_d  = shadow_q;
            cout_d = msb_cout_q;
            ovf_d  = msb_cin_q ^ msb_cout_q;
        end
    end

    // ---------------- Digit select ----------------
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_dig = a_q[i*DIGIT_WIDTH +: DIGIT_WIDTH];
                b_dig = b_q[i*DIGIT_WIDTH +: DIGIT_WIDTH];
            end
        end
    end

    // ---------------- Full-adder ripple for one digit ----------------
    always_comb begin
        c_chain    = '0;
        s_dig      = '0;
        c_chain[0] = carry_q;
        for (int j = 0; j < DIGIT_WIDTH; j++) begin
            s_dig[j]     = a_dig[j] ^ b_dig[j] ^ c_chain[j];
            c_chain[j+1] = (a_dig[j] & b_dig[j]) | (c_chain[j] & (a_dig[j] ^ b_dig[j]));
        end
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        msb_cin_d  = msb_cin_q;
        msb_cout_d = msb_cout_q;
        if (start_acc) begin
            // Subtraction is A + ~B + 1; a borrow-in removes that +1.
            a_d     = bus.Data_A_In;
            b_d     = bus.Sub_In ? ~bus.Data_B_In : bus.Data_B_In;
            carry_d = bus.Carry_In ^ bus.Sub_In;
            cnt_d   = '0;
        end else if (state_q == ADD) begin
            carry_d = c_chain[DIGIT_WIDTH];
            cnt_d   = cnt_q + CNT_W'(1);
            for (int i = 0; i < N; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    shadow_d[i*DIGIT_WIDTH +: DIGIT_WIDTH] = s_dig;
                end
            end
            // The top slice of the last digit is the word MSB: keep the carry
            // entering and leaving it for the overflow flag.
            if (cnt_q == LAST_DIGIT) begin
                msb_cin_d  = c_chain[DIGIT_WIDTH-1];
                msb_cout_d = c_chain[DIGIT_WIDTH];
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            msb_cin_q  <= 1'b0;
            msb_cout_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            msb_cin_q  <= msb_cin_d;
            msb_cout_q <= msb_cout_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.Sum_Out      = sum_q;
    assign bus.Carry_Out    = cout_q;
    assign bus.Overflow_Out = ovf_q;
    assign bus.Busy_Out     = busy_q;
    assign bus.Done_Out     = done_q;

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Bench for multi_cycle_adder: directed handshake/reset steps on an (8,2) instance,
// then random operations on (8,2), (8,1), (8,8), (16,4) and (32,8) instances,
// each checked against an arithmetic reference model and exact N+1 latency.
module tb_multi_cycle_adder;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    multi_cycle_adder_if #(.WIDTH(8))  if0 ();
    multi_cycle_adder_if #(.WIDTH(8))  if1 ();
    multi_cycle_adder_if #(.WIDTH(8))  if2 ();
    multi_cycle_adder_if #(.WIDTH(16)) if3 ();
    multi_cycle_adder_if #(.WIDTH(32)) if4 ();

    multi_cycle_adder #(.WIDTH(8),  .DIGIT_WIDTH(2)) u0 (.Clock(Clock), .Reset(Reset), .bus(if0));
    multi_cycle_adder #(.WIDTH(8),  .DIGIT_WIDTH(1)) u1 (.Clock(Clock), .Reset(Reset), .bus(if1));
    multi_cycle_adder #(.WIDTH(8),  .DIGIT_WIDTH(8)) u2 (.Clock(Clock), .Reset(Reset), .bus(if2));
    multi_cycle_adder #(.WIDTH(16), .DIGIT_WIDTH(4)) u3 (.Clock(Clock), .Reset(Reset), .bus(if3));
    multi_cycle_adder #(.WIDTH(32), .DIGIT_WIDTH(8)) u4 (.Clock(Clock), .Reset(Reset), .bus(if4));

    int w_of[5] = '{8, 8, 8, 16, 32};
    int n_of[5] = '{4, 8, 1, 4, 4};

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void ref_op(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                   input logic cin, input logic sub,
                                   output logic [31:0] sum, output logic cout, output logic ovf);
        logic [31:0] mask32;
        longint ua, ub, ci, full, sa, sb, res, lim;
        mask32 = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = longint'({32'd0, a_in & mask32});
        ub = longint'({32'd0, b_in & mask32});
        ci = cin ? 64'sd1 : 64'sd0;
        if (!sub) begin
            full = ua + ub + ci;
            cout = (full >= (longint'(1) << w));
        end else begin
            full = ua - ub - ci;
            cout = (ua >= ub + ci);
        end
        sum = 32'(full) & mask32;
        lim = longint'(1) << (w - 1);
        sa  = (ua >= lim) ? ua - (longint'(1) << w) : ua;
        sb  = (ub >= lim) ? ub - (longint'(1) << w) : ub;
        res = sub ? (sa - sb - ci) : (sa + sb + ci);
        ovf = (res >= lim) || (res < -lim);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive0(input logic [7:0] a, input logic [7:0] b, input logic c,
                          input logic s, input logic st);
        if0.Data_A_In = a;
        if0.Data_B_In = b;
        if0.Carry_In  = c;
        if0.Sub_In    = s;
        if0.Start_In  = st;
    endtask

    task automatic drive_all(input logic [31:0] a, input logic [31:0] b, input logic c,
                             input logic s, input logic st);
        drive0(a[7:0], b[7:0], c, s, st);
        if1.Data_A_In = a[7:0];  if1.Data_B_In = b[7:0];  if1.Carry_In = c; if1.Sub_In = s; if1.Start_In = st;
        if2.Data_A_In = a[7:0];  if2.Data_B_In = b[7:0];  if2.Carry_In = c; if2.Sub_In = s; if2.Start_In = st;
        if3.Data_A_In = a[15:0]; if3.Data_B_In = b[15:0]; if3.Carry_In = c; if3.Sub_In = s; if3.Start_In = st;
        if4.Data_A_In = a;       if4.Data_B_In = b;       if4.Carry_In = c; if4.Sub_In = s; if4.Start_In = st;
    endtask

    // One operation on the (8,2) instance from IDLE: checks Busy cycles 1-4,
    // Done only at cycle 5, results held until then and correct at cycle 5.
    task automatic run_op0(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic sub);
        logic [31:0] es;
        logic        ec, eo;
        logic [7:0]  prev_s;
        logic [1:0]  prev_f;
        ref_op(8, 32'(a), 32'(b), cin, sub, es, ec, eo);
        prev_s = if0.Sum_Out;
        prev_f = {if0.Carry_Out, if0.Overflow_Out};
        drive0(a, b, cin, sub, 1'b1);
        tick();
        drive0(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("%s_busy_c%0d", tag, c), 64'(if0.Busy_Out), 64'(c <= 4));
            chk($sformatf("%s_done_c%0d", tag, c), 64'(if0.Done_Out), 64'(c == 5));
            if (c < 5) begin
                chk($sformatf("%s_hold_c%0d", tag, c),
                    64'({if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out}), 64'({prev_f, prev_s}));
            end
        end
        chk({tag, "_sum"},  64'(if0.Sum_Out),      64'(es[7:0]));
        chk({tag, "_cout"}, 64'(if0.Carry_Out),    64'(ec));
        chk({tag, "_ovf"},  64'(if0.Overflow_Out), 64'(eo));
        tick();
        chk({tag, "_done_c6"}, 64'(if0.Done_Out), 64'd0);
    endtask

    initial begin : main
        logic [31:0] ra, rb, es;
        logic        rc, rsub, ec, eo;
        int          dcnt[5];
        int          dat[5];
        logic [31:0] got_s[5];
        logic [1:0]  got_f[5];
        logic [31:0] seen_s[$];
        int          seen_c[$];
        logic [31:0] e2s;
        logic        e2c, e2o;

        drive_all(32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b1;
        tick();
        tick();
        chk("rst_sum",  64'(if0.Sum_Out),      64'd0);
        chk("rst_cout", 64'(if0.Carry_Out),    64'd0);
        chk("rst_ovf",  64'(if0.Overflow_Out), 64'd0);
        chk("rst_busy", 64'(if0.Busy_Out),     64'd0);
        chk("rst_done", 64'(if0.Done_Out),     64'd0);
        Reset = 1'b0;
        tick();

        // Directed arithmetic corner cases
        run_op0("wrap",  8'hFF, 8'h01, 1'b0, 1'b0);
        chk("wrap_const", 64'({if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out}), 64'({1'b1, 1'b0, 8'h00}));
        run_op0("sovf",  8'h7F, 8'h01, 1'b0, 1'b0);
        chk("sovf_const", 64'({if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out}), 64'({1'b0, 1'b1, 8'h80}));
        run_op0("borrow", 8'h05, 8'h07, 1'b0, 1'b1);
        chk("borrow_const", 64'({if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out}), 64'({1'b0, 1'b0, 8'hFE}));
        run_op0("bin",   8'h80, 8'h01, 1'b1, 1'b1);
        chk("bin_const", 64'({if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out}), 64'({1'b1, 1'b1, 8'h7E}));

        // Start pulsed while busy is ignored
        ref_op(8, 32'h12, 32'h34, 1'b0, 1'b0, es, ec, eo);
        drive0(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
        tick();
        drive0(8'hAA, 8'h55, 1'b1, 1'b1, 1'b0);
        seen_c.delete();
        seen_s.delete();
        for (int c = 1; c <= 9; c++) begin
            if (c == 1) if0.Start_In = 1'b1;
            tick();
            if (c == 2) if0.Start_In = 1'b0;
            if (if0.Done_Out) begin
                seen_c.push_back(c);
                seen_s.push_back(32'(if0.Sum_Out));
            end
        end
        chk("ign_pulses", 64'(seen_c.size()), 64'd1);
        if (seen_c.size() >= 1) begin
            chk("ign_done_cyc", 64'(seen_c[0]), 64'd5);
            chk("ign_sum", 64'(seen_s[0]), 64'(es));
        end
        chk("ign_busy_c9", 64'(if0.Busy_Out), 64'd0);

        // Start held high through DONE: back-to-back second operation
        ref_op(8, 32'h10, 32'h20, 1'b1, 1'b0, es, ec, eo);
        ref_op(8, 32'h90, 32'h30, 1'b0, 1'b1, e2s, e2c, e2o);
        drive0(8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
        tick();
        drive0(8'h90, 8'h30, 1'b0, 1'b1, 1'b1);
        seen_c.delete();
        seen_s.delete();
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 5) if0.Start_In = 1'b0;
            if (c == 6) chk("b2b_busy_c6", 64'(if0.Busy_Out), 64'd1);
            if (if0.Done_Out) begin
                seen_c.push_back(c);
                seen_s.push_back({22'd0, if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out});
            end
        end
        chk("b2b_pulses", 64'(seen_c.size()), 64'd2);
        if (seen_c.size() == 2) begin
            chk("b2b_done1_cyc", 64'(seen_c[0]), 64'd5);
            chk("b2b_res1", 64'(seen_s[0]), 64'({22'd0, ec, eo, es[7:0]}));
            chk("b2b_done2_cyc", 64'(seen_c[1]), 64'd10);
            chk("b2b_res2", 64'(seen_s[1]), 64'({22'd0, e2c, e2o, e2s[7:0]}));
        end

        // Reset mid-operation discards the op; outputs clear
        drive0(8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
        tick();
        if0.Start_In = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mrst_c3_outs", 64'({if0.Busy_Out, if0.Done_Out, if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out}), 64'd0);
        seen_c.delete();
        for (int c = 4; c <= 9; c++) begin
            tick();
            if (c == 4) begin
                chk("mrst_c4_outs", 64'({if0.Busy_Out, if0.Done_Out, if0.Carry_Out, if0.Overflow_Out, if0.Sum_Out}), 64'd0);
            end
            if (if0.Done_Out || if0.Busy_Out) seen_c.push_back(c);
        end
        chk("mrst_no_activity", 64'(seen_c.size()), 64'd0);
        run_op0("after_rst", 8'hA5, 8'h5A, 1'b1, 1'b0);

        // A few random ops with full per-cycle checks on the (8,2) instance
        for (int i = 0; i < 20; i++) begin
            run_op0($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // Parameter sweep: all instances run the same random operands in lockstep
        for (int op = 0; op < 500; op++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom);
            rsub = 1'($urandom);
            drive_all(ra, rb, rc, rsub, 1'b1);
            tick();
            drive_all($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
            for (int k = 0; k < 5; k++) begin
                dcnt[k]  = 0;
                dat[k]   = 0;
                got_s[k] = '0;
                got_f[k] = '0;
            end
            for (int c = 1; c <= 10; c++) begin
                tick();
                if (if0.Done_Out) begin dcnt[0]++; if (dcnt[0] == 1) dat[0] = c; got_s[0] = 32'(if0.Sum_Out); got_f[0] = {if0.Carry_Out, if0.Overflow_Out}; end
                if (if1.Done_Out) begin dcnt[1]++; if (dcnt[1] == 1) dat[1] = c; got_s[1] = 32'(if1.Sum_Out); got_f[1] = {if1.Carry_Out, if1.Overflow_Out}; end
                if (if2.Done_Out) begin dcnt[2]++; if (dcnt[2] == 1) dat[2] = c; got_s[2] = 32'(if2.Sum_Out); got_f[2] = {if2.Carry_Out, if2.Overflow_Out}; end
                if (if3.Done_Out) begin dcnt[3]++; if (dcnt[3] == 1) dat[3] = c; got_s[3] = 32'(if3.Sum_Out); got_f[3] = {if3.Carry_Out, if3.Overflow_Out}; end
                if (if4.Done_Out) begin dcnt[4]++; if (dcnt[4] == 1) dat[4] = c; got_s[4] = if4.Sum_Out;      got_f[4] = {if4.Carry_Out, if4.Overflow_Out}; end
            end
            for (int k = 0; k < 5; k++) begin
                ref_op(w_of[k], ra, rb, rc, rsub, es, ec, eo);
                chk($sformatf("sw%0d_op%0d_pulses", k, op), 64'(dcnt[k]), 64'd1);
                chk($sformatf("sw%0d_op%0d_latency", k, op), 64'(dat[k]), 64'(n_of[k] + 1));
                chk($sformatf("sw%0d_op%0d_sum", k, op), 64'(got_s[k]), 64'(es));
                chk($sformatf("sw%0d_op%0d_flags", k, op), 64'(got_f[k]), 64'({ec, eo}));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
